// File: rtl/psu_cwdarrrecv.sv
// psu_cwdarrrecv: qubit-plane-side receiver for the PSU codeword array.
//
// Captures one full NUM_PQ x CWD_BW codeword array over a valid/ready
// handshake, then streams it out as CHUNK-qubit beats. With SKIP_IDLE=1,
// chunks whose codewords are all CWD_I are never emitted. For every captured
// array the per-qubit active mask (codeword != CWD_I) and a popcount of it
// are kept.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       codeword array valid
//   in_ready       receiver idle and able to capture an array
//   in_cwdarray    codeword array, qubit i at [i*CWD_BW +: CWD_BW]
//   out_valid      output beat valid
//   out_ready      downstream accepts the beat
//   out_chunk      codewords of qubits base..base+CHUNK-1, same packing
//   out_base_idx   index of the first qubit in out_chunk
//   out_active     per-qubit flag for out_chunk, codeword != CWD_I
//   out_last       final emitted beat of the current array
//   done           one-cycle pulse when an array is fully drained
//   active_cnt     non-idle qubit count of the last captured array

// Per-qubit idle detector, one instance per qubit.
module psu_cwdarrrecv_lane #(
    parameter int CWD_BW = 3,
    parameter int CWD_I  = 0
) (
    input  logic [CWD_BW-1:0] cwd,
    output logic              act
);
    assign act = (cwd != CWD_BW'(CWD_I));
endmodule

module psu_cwdarrrecv #(
    parameter int NUM_PQ    = 16,
    parameter int CWD_BW    = 3,
    parameter int CWD_I     = 0,
    parameter int CHUNK     = 4,
    parameter int SKIP_IDLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_PQ*CWD_BW-1:0]    in_cwdarray,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHUNK*CWD_BW-1:0]     out_chunk,
    output logic [$clog2(NUM_PQ)-1:0]   out_base_idx,
    output logic [CHUNK-1:0]            out_active,
    output logic                        out_last,
    output logic                        done,
    output logic [$clog2(NUM_PQ+1)-1:0] active_cnt
);
    localparam int NCH  = NUM_PQ / CHUNK;
    localparam int CIW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IDXW = $clog2(NUM_PQ);
    localparam int CNTW = $clog2(NUM_PQ + 1);
    localparam int AW   = NUM_PQ * CWD_BW;
    localparam int BW   = CHUNK * CWD_BW;
    localparam logic [CWD_BW-1:0] CI = CWD_BW'(CWD_I);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_d;

    logic [AW-1:0]     buf_q;
    logic [NUM_PQ-1:0] act_q;
    logic [NCH-1:0]    elig_q;
    logic [CIW-1:0]    cur_q;

    logic [NUM_PQ-1:0] in_act;
    logic [NCH-1:0]    in_elig;
    logic [CNTW-1:0]   cnt_d;

    logic              cap, adv, fin;
    logic [CIW:0]      first, nxt, tail;
    logic [CIW-1:0]    sel_idx;
    logic [BW-1:0]     sel_chunk;
    logic [CHUNK-1:0]  sel_act;
    logic              sel_last;

    // Lowest set bit of v at or above index 'from'; MSB of the result is a
    // found flag. Purely combinational priority scan.
    function automatic logic [CIW:0] scan(input logic [NCH-1:0] v, input int from);
        logic [CIW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= from && v[i]) r = {1'b1, CIW'(i)};
        end
        return r;
    endfunction

    for (genvar q = 0; q < NUM_PQ; q++) begin : g_lane
        psu_cwdarrrecv_lane #(.CWD_BW(CWD_BW), .CWD_I(CWD_I)) u_lane (
            .cwd (in_cwdarray[q*CWD_BW +: CWD_BW]),
            .act (in_act[q])
        );
    end

    // Chunks eligible for emission: all of them, or only those with any
    // active qubit when idle chunks are skipped.
    always_comb begin
        in_elig = '0;
        for (int c = 0; c < NCH; c++) begin
            in_elig[c] = (SKIP_IDLE == 0) ? 1'b1 : |in_act[c*CHUNK +: CHUNK];
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_PQ; i++) cnt_d = cnt_d + CNTW'(in_act[i]);
    end

    assign first = scan(in_elig, 0);
    assign nxt   = scan(elig_q, int'(cur_q) + 1);

    // FSM next state and control strobes
    always_comb begin
        state_d = state;
        cap     = 1'b0;
        adv     = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    cap = 1'b1;
                    if (first[CIW]) state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (out_last) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat to load next: the first chunk straight from the input on capture,
    // otherwise the next eligible chunk from the capture buffer. out_last is
    // precomputed by checking whether any eligible chunk lies above it.
    always_comb begin
        sel_idx   = cap ? first[CIW-1:0] : nxt[CIW-1:0];
        sel_chunk = cap ? in_cwdarray[int'(sel_idx)*BW +: BW]
                        : buf_q[int'(sel_idx)*BW +: BW];
        sel_act   = cap ? in_act[int'(sel_idx)*CHUNK +: CHUNK]
                        : act_q[int'(sel_idx)*CHUNK +: CHUNK];
        tail      = scan(cap ? in_elig : elig_q, int'(sel_idx) + 1);
        sel_last  = !tail[CIW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q        <= '0;
            act_q        <= '0;
            elig_q       <= '0;
            cur_q        <= '0;
            out_chunk    <= {CHUNK{CI}};
            out_base_idx <= '0;
            out_active   <= '0;
            out_last     <= 1'b0;
            done         <= 1'b0;
            active_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (cap) begin
                buf_q      <= in_cwdarray;
                act_q      <= in_act;
                elig_q     <= in_elig;
                active_cnt <= cnt_d;
                // nothing to emit: the array is drained on arrival
                if (!first[CIW]) done <= 1'b1;
            end
            if ((cap && first[CIW]) || adv) begin
                cur_q        <= sel_idx;
                out_chunk    <= sel_chunk;
                out_active   <= sel_act;
                out_base_idx <= IDXW'(int'(sel_idx) * CHUNK);
                out_last     <= sel_last;
            end
            if (fin) done <= 1'b1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SEND);

endmodule

// File: tb/tb_psu_cwdarrrecv.sv
// Bench for psu_cwdarrrecv: two instances (SKIP_IDLE=1 and SKIP_IDLE=0)
// share the same stimulus; a list-based reference model per instance
// predicts every output on every cycle.
module tb_psu_cwdarrrecv;
    localparam int NQ  = 16;
    localparam int CB  = 3;
    localparam int CH  = 4;
    localparam int NCH = NQ / CH;
    localparam int W   = NQ * CB;
    localparam int BW  = CH * CB;

    logic clk, rst_n;
    logic in_valid, out_ready;
    logic [W-1:0] in_cwdarray;

    logic          ir [2];
    logic          ov [2];
    logic          ol [2];
    logic          dn [2];
    logic [BW-1:0] oc [2];
    logic [3:0]    ob [2];
    logic [CH-1:0] oa [2];
    logic [4:0]    ac [2];

    int n_chk = 0;
    int n_err = 0;

    psu_cwdarrrecv #(.SKIP_IDLE(1)) dut_sk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_cwdarray(in_cwdarray), .out_valid(ov[0]), .out_ready(out_ready),
        .out_chunk(oc[0]), .out_base_idx(ob[0]), .out_active(oa[0]),
        .out_last(ol[0]), .done(dn[0]), .active_cnt(ac[0]));

    psu_cwdarrrecv #(.SKIP_IDLE(0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_cwdarray(in_cwdarray), .out_valid(ov[1]), .out_ready(out_ready),
        .out_chunk(oc[1]), .out_base_idx(ob[1]), .out_active(oa[1]),
        .out_last(ol[1]), .done(dn[1]), .active_cnt(ac[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: on capture, build the list of chunk indices that will
    // be emitted; each accepted beat walks one step down the list.
    logic [W-1:0] m_arr [2];
    int           m_lst [2][NCH];
    int           m_n   [2];
    int           m_pos [2];
    int           m_cnt [2];
    bit           m_busy[2];
    bit           m_done[2];

    always @(posedge clk or negedge rst_n) begin
        int  n, cnt;
        bit  any;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0;
                m_done[d] <= 1'b0;
                m_cnt[d]  <= 0;
                m_pos[d]  <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_done[d] <= 1'b0;
                if (!m_busy[d]) begin
                    if (in_valid) begin
                        n = 0;
                        cnt = 0;
                        for (int c = 0; c < NCH; c++) begin
                            any = 1'b0;
                            for (int j = 0; j < CH; j++) begin
                                if (in_cwdarray[(c*CH+j)*CB +: CB] != 0) begin
                                    any = 1'b1;
                                    cnt++;
                                end
                            end
                            if (d == 1 || any) begin
                                m_lst[d][n] <= c;
                                n++;
                            end
                        end
                        m_arr[d] <= in_cwdarray;
                        m_n[d]   <= n;
                        m_pos[d] <= 0;
                        m_cnt[d] <= cnt;
                        if (n > 0) m_busy[d] <= 1'b1;
                        else       m_done[d] <= 1'b1;
                    end
                end else if (out_ready) begin
                    if (m_pos[d] == m_n[d] - 1) begin
                        m_busy[d] <= 1'b0;
                        m_done[d] <= 1'b1;
                    end else begin
                        m_pos[d] <= m_pos[d] + 1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    always @(negedge clk) begin
        string p;
        int b;
        logic [CH-1:0] ea;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? "sk" : "ns";
            chk({p, ".in_ready"},   32'(ir[d]), 32'(!m_busy[d]));
            chk({p, ".out_valid"},  32'(ov[d]), 32'(m_busy[d]));
            chk({p, ".done"},       32'(dn[d]), 32'(m_done[d]));
            chk({p, ".active_cnt"}, 32'(ac[d]), 32'(m_cnt[d]));
            if (m_busy[d]) begin
                b = m_lst[d][m_pos[d]] * CH;
                for (int j = 0; j < CH; j++) ea[j] = (m_arr[d][(b+j)*CB +: CB] != 0);
                chk({p, ".base"},   32'(ob[d]), 32'(b));
                chk({p, ".chunk"},  32'(oc[d]), 32'(m_arr[d][b*CB +: BW]));
                chk({p, ".active"}, 32'(oa[d]), 32'(ea));
                chk({p, ".last"},   32'(ol[d]), 32'(m_pos[d] == m_n[d] - 1));
            end
        end
    end

    task automatic rst_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, ".valid"}, 32'(ov[d]), 32'd0);
            chk({tag, ".ready"}, 32'(ir[d]), 32'd1);
            chk({tag, ".done"},  32'(dn[d]), 32'd0);
            chk({tag, ".chunk"}, 32'(oc[d]), 32'd0);
            chk({tag, ".base"},  32'(ob[d]), 32'd0);
            chk({tag, ".act"},   32'(oa[d]), 32'd0);
            chk({tag, ".last"},  32'(ol[d]), 32'd0);
        end
    endtask

    task automatic send(input logic [W-1:0] a);
        @(posedge clk); #1;
        in_valid    = 1'b1;
        in_cwdarray = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((m_busy[0] || m_busy[1]) && k < max) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_timeout", 32'(m_busy[0] | m_busy[1]), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rand_arr(input int dens);
        logic [W-1:0] a = '0;
        for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 99) < 35) continue;
            for (int j = 0; j < CH; j++) begin
                if ($urandom_range(0, 99) < dens)
                    a[(c*CH+j)*CB +: CB] = CB'($urandom_range(1, 7));
            end
        end
        return a;
    endfunction

    initial begin
        logic [W-1:0] a;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_cwdarray = '0;
        out_ready = 1'b1;
        #3;
        rst_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // qubit 0 = 101, qubit 5 = 010
        a = '0;
        a[0*CB +: CB] = 3'b101;
        a[5*CB +: CB] = 3'b010;
        send(a);
        wait_idle(40);

        // all idle
        send('0);
        wait_idle(40);

        // backpressure on the first beat, then a new array held during SEND
        a = rand_arr(70);
        a[2*CB +: CB] = 3'b111;
        out_ready = 1'b0;
        send(a);
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_cwdarray = {W{1'b1}};
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        wait_idle(60);

        // all 16 active
        for (int q = 0; q < NQ; q++) a[q*CB +: CB] = CB'(q % 7 + 1);
        send(a);
        wait_idle(40);

        // asynchronous reset after the first beat
        send({W{1'b1}});
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        rst_vals("async_rst");
        @(negedge clk); #2;
        rst_n = 1'b1;
        a = '0;
        a[9*CB +: CB] = 3'b011;
        send(a);
        wait_idle(40);

        // random traffic
        repeat (600) begin
            @(posedge clk); #1;
            in_valid    = ($urandom_range(0, 2) == 0);
            in_cwdarray = rand_arr($urandom_range(0, 100));
            out_ready   = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(60);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/psu_cwdarrrecv.md
Name: psu_cwdarrrecv

Overview:
- Qubit-plane-side receiver for the PSU codeword array.
- Accepts one full per-qubit codeword array (NUM_PQ x CWD_BW) over a valid/ready handshake and holds it in a capture buffer.
- Streams it out to the DAC/qubit-control interface as CHUNK-qubit beats, optionally skipping all-idle chunks.
- Also reconstructs the per-qubit active mask (codeword != CWD_I) and an active-qubit count for each captured array.

Parameters:
NUM_PQ, 16, number of physical qubits per array (set from the global define in integration)
CWD_BW, 3, codeword width per qubit
CWD_I, 0, idle/identity codeword value
CHUNK, 4, qubits per output beat; NUM_PQ must be a multiple of CHUNK
SKIP_IDLE, 1, 1 = chunks whose codewords are all CWD_I are not emitted

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  codeword array valid
in_ready  out  1  receiver can capture an array
in_cwdarray  in  NUM_PQ*CWD_BW  codeword array; qubit i at bits [i*CWD_BW +: CWD_BW]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_chunk  out  CHUNK*CWD_BW  codewords of qubits base..base+CHUNK-1, same packing
out_base_idx  out  clog2(NUM_PQ)  index of first qubit in out_chunk
out_active  out  CHUNK  per-qubit flag, codeword != CWD_I
out_last  out  1  final emitted beat of the current array
done  out  1  one-cycle pulse when an array is fully drained
active_cnt  out  clog2(NUM_PQ+1)  number of non-idle qubits in the last captured array

Behaviour:
- Single clock domain. Asynchronous active-low reset, applied to all state.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_last=0, done=0, out_chunk=all CWD_I, out_base_idx=0, out_active=0, active_cnt=0.
- FSM states: IDLE, SEND.
  - in_ready = (state==IDLE).
- Capture (IDLE, in_valid=1 at edge T):
  - Register the array, per-qubit active mask, and popcount (active_cnt updates at T+1 and holds until the next capture).
  - Compute the first chunk to emit: chunk 0 if SKIP_IDLE=0, else the lowest chunk with any active qubit.
  - If such a chunk exists: go to SEND; out_valid=1 at T+1 with that chunk (latency 1).
  - If none exists (SKIP_IDLE=1 and the whole array is idle): stay in IDLE; done=1 at T+1; out_valid stays 0.
- SEND:
  - out_chunk, out_base_idx, out_active and out_last are registered and held stable while out_valid && !out_ready.
  - On out_valid && out_ready:
    - If out_last: go to IDLE, out_valid=0 and done=1 next cycle; in_ready=1 next cycle. No same-cycle re-capture.
    - Else: advance to the next emitted chunk (next index; with SKIP_IDLE, next higher chunk with any active qubit) the following cycle. Beats are back-to-back while out_ready stays high.
- out_base_idx = chunk_index*CHUNK.
- out_last = 1 iff no later chunk would be emitted.
  - SKIP_IDLE=0: the last chunk is NUM_PQ/CHUNK-1.
- in_valid while in SEND is ignored (in_ready=0); the sender must hold it.
- done is a one-cycle pulse only, never held.
- Reset mid-SEND: the array is discarded, outputs return to reset values, and no done pulse is generated.
- Chunk search is a combinational priority scan over the registered chunk-active vector, one chunk per beat; no multi-cycle search.

Test Plan:
- Defaults. Reset, then capture an array with qubit 0=3'b101 and qubit 5=3'b010, rest 0 -> out_valid at T+1 with base 0, out_active=4'b0001. Next beat: base 4, out_active=4'b0010, out_last=1. Then done pulse; active_cnt=2.
- SKIP_IDLE=0, all-idle array -> 4 beats at bases 0, 4, 8, 12, all CWD_I, out_last on base 12; done=1 the cycle after; active_cnt=0.
- SKIP_IDLE=1, all-idle array -> out_valid never asserted; done=1 at T+1; in_ready stays 1.
- Backpressure: hold out_ready=0 for 5 cycles on the first beat -> out_chunk/base/active/last stable. Drive in_valid with a new array during SEND -> in_ready=0 and no capture until after the done pulse.
- All 16 qubits active, out_ready=1 constant -> 4 consecutive beats with no bubbles; active_cnt=16.
- Assert rst_n=0 asynchronously mid-SEND (after beat 1) -> outputs go to reset values immediately and no done pulse. After release, a new array is accepted and emitted starting from its first chunk.
